// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Byte PC to instruction-memory word index.
    function automatic logic [31:0] word_index(input logic [31:0] byte_pc);
        return byte_pc >> 2;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the fetch sequencer's memory, redirect, halt and decode-side signals.
// master: the sequencer itself; slave: the surrounding memory/decode/control logic.
interface fetch_sequencer_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        br_valid;
    logic [31:0] br_target;
    logic        halt_req;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        halted;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  br_valid,
        input  br_target,
        input  halt_req,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output br_valid,
        output br_target,
        output halt_req,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc,
        input  halted
    );

endinterface

// File: rtl/fetch_queue.sv
// Prefetch queue: circular buffer of fetch entries with push/pop/flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next pointers/occupancy: flush wins, pop on empty is dropped, push on full needs a same-cycle pop.
    always_comb begin
        // NOTE: every always_comb output is given a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (flush) begin
            do_pop   = 1'b0;
            do_push  = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage, written only on an accepted push.
    // NOTE: storage is deliberately not reset; its contents only matter while empty is low.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry;
    end

    // Pointer and occupancy registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: fetch PC, prefetch queue, branch redirect, halt/drain.
// Optional feature macro FETCH_BYPASS_EN: with an empty queue in RUN the memory word is
// offered to decode combinationally, saving one cycle of latency after reset or redirect.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  bus
);

    fetch_state_e           state_q, state_d;
    logic [31:0]            fetch_pc_q, fetch_pc_d;
    fetch_entry_t           q_head, q_push_entry;
    logic                   q_push, q_pop, q_flush, q_full, q_empty;
    logic [$clog2(DEPTH):0] q_count;
    logic                   redirect, fetch_en, bypass_vld, bypass_take;
    logic                   if_valid_c;
    logic [31:0]            if_pc_c, if_instr_c;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (q_push),
        .push_entry (q_push_entry),
        .pop        (q_pop),
        .flush      (q_flush),
        .head       (q_head),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count)
    );

    assign q_push_entry = '{pc: fetch_pc_q, instr: bus.imem_instr};
    assign bus.imem_addr = word_index(fetch_pc_q);
    assign bus.halted    = (state_q == HALTED);
    assign bus.if_valid  = if_valid_c;
    assign bus.if_pc     = if_pc_c;
    assign bus.if_instr  = if_instr_c;

    // Queue control, decode outputs and PC update; redirect outranks halt, halt outranks fetch.
    always_comb begin
        redirect = bus.br_valid && (state_q != BOOT);
        fetch_en = (state_q == RUN) && !bus.halt_req && !redirect;
`ifdef FETCH_BYPASS_EN
        // A pending halt also blocks the bypass so no fetch happens once halt is requested.
        bypass_vld = q_empty && (state_q == RUN) && !bus.br_valid && !bus.halt_req;
`else
        bypass_vld = 1'b0;
`endif
        bypass_take = bypass_vld && bus.if_ready;

        if_valid_c = 1'b0;
        if_pc_c    = '0;
        if_instr_c = '0;
        if (!q_empty) begin
            if_valid_c = 1'b1;
            if_pc_c    = q_head.pc;
            if_instr_c = q_head.instr;
        end else if (bypass_vld) begin
            if_valid_c = 1'b1;
            if_pc_c    = fetch_pc_q;
            if_instr_c = bus.imem_instr;
        end

        q_flush = redirect;
        q_pop   = !q_empty && bus.if_ready && !redirect;
        q_push  = fetch_en && (!q_full || q_pop) && !bypass_take;

        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = bus.br_target & ~32'h3;
        end else if (q_push || bypass_take) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
    end

    // Next-state logic; a redirect empties the queue, so DRAIN can finish at once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (bus.halt_req) state_d = DRAIN;
            DRAIN: begin
                if (redirect)           state_d = HALTED;
                else if (!bus.halt_req) state_d = RUN;
                else if (q_count == '0) state_d = HALTED;
            end
            HALTED:  if (!bus.halt_req) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // State and fetch-PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic, with a scoreboard
// holding the instruction stream decode should see (consecutive words, restarting at
// each redirect target) and a monitor comparing every completed handshake against it.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int vectors     = 0;
    int miscompares = 0;
    int deliveries  = 0;

    fetch_sequencer_if bus_if ();

    fetch_sequencer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a word per index, distinct and non-zero at index 0.
    function automatic logic [31:0] mem_word(input logic [31:0] idx);
        return (idx * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign bus_if.imem_instr = mem_word(bus_if.imem_addr);

    // Reference model: the ordered stream of instructions decode must receive.
    fetch_entry_t exp_q[$];
    logic [31:0]  model_pc;

    function automatic void top_up();
        fetch_entry_t e;
        while (exp_q.size() < 8) begin
            e.pc    = model_pc;
            e.instr = mem_word(model_pc / 4);
            exp_q.push_back(e);
            model_pc = model_pc + 32'd4;
        end
    endfunction

    function automatic void model_redirect(input logic [31:0] target);
        exp_q.delete();
        model_pc = {target[31:2], 2'b00};
        top_up();
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        model_pc = RESET_PC;
        top_up();
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_if_valid", bus_if.if_valid, 1'b0);
        check("rst_if_pc", bus_if.if_pc, 32'h0);
        check("rst_if_instr", bus_if.if_instr, 32'h0);
        check("rst_halted", bus_if.halted, 1'b0);
        check("rst_imem_addr", bus_if.imem_addr, RESET_PC >> 2);
        model_reset();
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for if_valid; returns positioned at a negedge.
    task automatic wait_valid(input string name, input int budget);
        int i = 0;
        @(negedge clk);
        while (!bus_if.if_valid && i < budget) begin
            next_cycle();
            @(negedge clk);
            i++;
        end
        check(name, bus_if.if_valid, 1'b1);
    endtask

    // Monitor: scoreboard on handshakes, hold-stability and halted-idle checks.
    initial begin
        fetch_entry_t e;
        logic         prev_hold;
        logic [31:0]  prev_pc, prev_instr;
        prev_hold  = 1'b0;
        prev_pc    = '0;
        prev_instr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", bus_if.if_valid, 1'b1);
                    check("hold_pc", bus_if.if_pc, prev_pc);
                    check("hold_instr", bus_if.if_instr, prev_instr);
                end
                if (bus_if.halted) check("halted_idle", bus_if.if_valid, 1'b0);
                if (bus_if.if_valid && bus_if.if_ready && !bus_if.br_valid) begin
                    e = exp_q.pop_front();
                    check("sb_pc", bus_if.if_pc, e.pc);
                    check("sb_instr", bus_if.if_instr, e.instr);
                    deliveries++;
                    top_up();
                end
                prev_hold  = bus_if.if_valid && !bus_if.if_ready && !bus_if.br_valid;
                prev_pc    = bus_if.if_pc;
                prev_instr = bus_if.if_instr;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        logic [31:0] resume_pc;
        logic [31:0] t;
        int          n0;
        int          rnd0;
        logic        got;

        bus_if.br_valid  = 1'b0;
        bus_if.br_target = '0;
        bus_if.halt_req  = 1'b0;
        bus_if.if_ready  = 1'b1;

        // Boot sequence with decode always ready.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 4) check("boot_imem_addr", bus_if.imem_addr, 32'(k - 1));
            if (k < 2) begin
                check("boot_no_valid", bus_if.if_valid, 1'b0);
            end else begin
                check("boot_if_pc", bus_if.if_pc, 32'(4 * (k - 2)));
                check("boot_if_instr", bus_if.if_instr, mem_word(32'(k - 2)));
            end
            next_cycle();
        end

        // Backpressure: queue fills, fetch PC parks at 8, head holds at 0.
        bus_if.if_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k >= 3) check("bp_imem_addr_hold", bus_if.imem_addr, 32'd2);
            if (k >= 2) check("bp_if_pc_hold", bus_if.if_pc, 32'h0);
            next_cycle();
        end
        bus_if.if_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_release_pc", bus_if.if_pc, 32'(4 * k));
            next_cycle();
        end

        // Redirect while the queue is full, decode ready in the same cycle.
        bus_if.if_ready = 1'b0;
        do_reset();
        repeat (4) next_cycle();
        bus_if.br_valid  = 1'b1;
        bus_if.br_target = 32'h39;
        bus_if.if_ready  = 1'b1;
        model_redirect(32'h39);
        next_cycle();
        bus_if.br_valid = 1'b0;
        @(negedge clk);
        check("redir_flushed", bus_if.if_valid, 1'b0);
        check("redir_imem_addr", bus_if.imem_addr, 32'd14);
        next_cycle();
        @(negedge clk);
        check("redir_valid", bus_if.if_valid, 1'b1);
        check("redir_if_pc", bus_if.if_pc, 32'h38);
        next_cycle();

        // Redirect and halt together in RUN.
        bus_if.br_valid  = 1'b1;
        bus_if.br_target = 32'h20;
        bus_if.halt_req  = 1'b1;
        model_redirect(32'h20);
        next_cycle();
        bus_if.br_valid = 1'b0;
        @(negedge clk);
        check("brhalt_imem_addr", bus_if.imem_addr, 32'd8);
        check("brhalt_not_yet_halted", bus_if.halted, 1'b0);
        check("brhalt_no_valid", bus_if.if_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        check("brhalt_halted", bus_if.halted, 1'b1);
        next_cycle();
        bus_if.halt_req = 1'b0;
        wait_valid("brhalt_resume_timeout", 6);
        check("brhalt_resume_pc", bus_if.if_pc, 32'h20);
        next_cycle();

        // Halt with two queued entries: both delivered, then halted, then resume.
        bus_if.if_ready = 1'b0;
        repeat (3) next_cycle();
        bus_if.halt_req = 1'b1;
        bus_if.if_ready = 1'b1;
        resume_pc = exp_q[2].pc;
        n0  = deliveries;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.halted) begin
                got = 1'b1;
                break;
            end
            next_cycle();
        end
        check("halt_reached", got, 1'b1);
        check("halt_drained_count", 32'(deliveries - n0), 32'd2);
        next_cycle();
        bus_if.halt_req = 1'b0;
        wait_valid("halt_resume_timeout", 6);
        check("halt_resume_pc", bus_if.if_pc, resume_pc);
        next_cycle();

        // Wrap-around of the fetch PC.
        bus_if.br_valid  = 1'b1;
        bus_if.br_target = 32'hFFFF_FFFC;
        model_redirect(32'hFFFF_FFFC);
        next_cycle();
        bus_if.br_valid = 1'b0;
        @(negedge clk);
        check("wrap_imem_addr_top", bus_if.imem_addr, 32'h3FFF_FFFF);
        next_cycle();
        @(negedge clk);
        check("wrap_if_pc_top", bus_if.if_pc, 32'hFFFF_FFFC);
        check("wrap_imem_addr_zero", bus_if.imem_addr, 32'h0);
        next_cycle();
        @(negedge clk);
        check("wrap_if_pc_zero", bus_if.if_pc, 32'h0);

        // Random traffic: ready, halt level, redirects, one mid-run reset.
        rnd0 = deliveries;
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            if (c == 1500) begin
                bus_if.br_valid = 1'b0;
                do_reset();
                continue;
            end
            bus_if.if_ready = ($urandom_range(3) != 0);
            if ($urandom_range(39) == 0) bus_if.halt_req = ~bus_if.halt_req;
            if ($urandom_range(24) == 0) begin
                t = $urandom;
                bus_if.br_valid  = 1'b1;
                bus_if.br_target = t;
                model_redirect(t);
            end else begin
                bus_if.br_valid = 1'b0;
            end
        end
        next_cycle();
        bus_if.br_valid = 1'b0;
        bus_if.halt_req = 1'b0;
        bus_if.if_ready = 1'b1;
        wait_valid("final_flow_timeout", 8);
        check("random_progress", 32'(deliveries - rnd0 > 200), 32'd1);
        next_cycle();
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that sequences the combinational instruction memory and feeds the decode stage. It holds the fetch PC, converts byte PCs to word indices, buffers fetched words in a small prefetch queue with a valid/ready handshake, and handles branch redirects and halt/drain. It sits between the instruction memory and the IF/ID pipeline register.

## Interface
- DEPTH, 2: prefetch queue entries; power of two, 2..8.
- RESET_PC, 32'h0: byte address of the first fetch after reset.
- clk  in  1  single clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset; asserts immediately and releases synchronously to clk.
- imem_addr  out  32  word index to the instruction memory, equal to {2'b00, fetch_pc[31:2]}.
- imem_instr  in  32  combinational read data for imem_addr, valid in the same cycle.
- br_valid  in  1  branch redirect request, highest priority.
- br_target  in  32  byte target address; bits [1:0] are ignored (forced to 0).
- halt_req  in  1  level; stops new fetches and drains the queue.
- if_valid  out  1  queue head is valid.
- if_ready  in  1  decode accepts the head this cycle when if_valid && if_ready.
- if_instr  out  32  head instruction word.
- if_pc  out  32  byte address of the head instruction.
- halted  out  1  high in state HALTED.

## Operation
- FSM states: BOOT, RUN, DRAIN, HALTED.
- BOOT: one cycle after reset release with no fetch, then RUN.
- RUN: each cycle in which the queue is not full, or is full but popping this cycle, push {fetch_pc, imem_instr} and advance fetch_pc by 4, wrapping modulo 2^32.
- RUN -> DRAIN when halt_req=1. Fetching stops in DRAIN, and the queue continues to pop.
- DRAIN -> HALTED when the queue is empty. DRAIN -> RUN if halt_req drops first.
- HALTED -> RUN when halt_req=0. fetch_pc is retained.
- Redirect (br_valid=1) in any state except BOOT:
  - Flush all queue entries.
  - Cancel any pop in the same cycle. No handshake completes, even if if_ready=1.
  - Load fetch_pc with {br_target[31:2], 2'b00}.
  - Suppress the push in that cycle.
  - The state is unchanged, except DRAIN goes to HALTED because the queue is now empty.
- Priority order: redirect > halt > fetch.
- The queue is a circular buffer with read and write pointers and an occupancy count of 0..DEPTH. Simultaneous push and pop with the queue full is legal and keeps the count at DEPTH. Pop with the queue empty is ignored.
- if_instr and if_pc are held stable while if_valid=1 and if_ready=0.

## Timing
- Reset values:
  - state=BOOT, fetch_pc=RESET_PC, queue count=0.
  - if_valid=0, if_instr=0, if_pc=0, halted=0.
  - imem_addr = RESET_PC>>2.
- Without bypass, the first if_valid rises 2 cycles after reset release: the BOOT cycle, then the push cycle, with valid on the following cycle.
- Redirect to first valid after the target: 2 cycles (redirect cycle, then push cycle) without bypass.
- Sustained throughput is 1 instruction per cycle with if_ready held high.
- halted rises the cycle after the queue becomes empty in DRAIN.
- Reset asserted mid-operation clears all state in the same instant. In-flight entries are lost.

## Configuration
- FETCH_BYPASS_EN defined:
  - When the queue is empty, state=RUN, and br_valid=0, imem_instr and fetch_pc drive if_instr/if_pc combinationally with if_valid=1.
  - If accepted, no push occurs and fetch_pc advances.
  - Latency drops by 1 cycle in both the reset and redirect cases.
- Undefined: every instruction passes through the queue, and all outputs are registered or derived from queue storage.

## Structure
- Shared package fetch_pkg holds:
  - the state enum (BOOT, RUN, DRAIN, HALTED);
  - the entry struct {pc[31:0], instr[31:0]};
  - the constant PC_STEP = 4.
- One sub-module, fetch_queue: a parameterised FIFO with push/pop/flush, full/empty, and count. The FSM, PC, and redirect logic stay in the top level.

## Test plan
- Reset with RESET_PC=0 and if_ready=1:
  - if_pc sequence 0, 4, 8, 12 on consecutive cycles.
  - imem_addr sequence 0, 1, 2, 3.
  - if_instr equals memory words 0..3.
- Backpressure: if_ready=0 for 5 cycles.
  - Queue fills to DEPTH=2, and fetch_pc stops at 8.
  - if_pc stays at 0 throughout.
  - On release, if_pc reads 0, 4, 8 with no loss or duplication.
- Redirect: br_valid=1 with br_target=32'h39 while the queue is full.
  - Queue flushes, and any pop that cycle is cancelled.
  - Next delivered if_pc = 32'h38, imem_addr = 14.
- Redirect and halt together: br_valid=1, br_target=0x20, halt_req=1 in RUN.
  - fetch_pc becomes 0x20 and the state goes to DRAIN.
  - halted=1 one cycle later, since the queue is empty.
- Halt with 2 queued entries and if_ready=1:
  - Both entries are delivered, then halted=1.
  - Dropping halt_req resumes fetching at the retained fetch_pc.
- Wrap-around: br_target=32'hFFFFFFFC, if_ready=1.
  - if_pc sequence FFFFFFFC, then 0.
  - imem_addr sequence 3FFFFFFF, then 0.
